four_bit_add_sub: RTL and testbench

- Registered 4-bit unsigned adder/subtractor with a sign-magnitude result for subtraction.
- ctrl selects the operation: 0 computes A+B, 1 computes A−B.
- Subtraction uses two's complement: B is XORed with ctrl, and ctrl is also the carry-in.
- A negative subtraction result is re-complemented and reported as magnitude plus a negative flag.
- Used as a small datapath arithmetic leaf; results appear one clock after the inputs are sampled.

---
 rtl/four_bit_add_sub_if.sv | 23 ++
 rtl/four_bit_add_sub.sv | 81 ++++++++
 tb/tb_four_bit_add_sub.sv | 110 +++++++++++
 3 files changed

// File: rtl/four_bit_add_sub_if.sv
// Operand/result bundle for four_bit_add_sub.
//   master: drives in_valid, A, B, ctrl; observes S, Cout, initialCout, out_valid
//   slave : the arithmetic block itself
interface four_bit_add_sub_if;
  logic       in_valid;
  logic [3:0] A;
  logic [3:0] B;
  logic       ctrl;
  logic [3:0] S;
  logic       Cout;
  logic       initialCout;
  logic       out_valid;

  modport master (
    output in_valid, A, B, ctrl,
    input  S, Cout, initialCout, out_valid
  );

  modport slave (
    input  in_valid, A, B, ctrl,
    output S, Cout, initialCout, out_valid
  );
endinterface

// File: rtl/four_bit_add_sub.sv
// Registered 4-bit unsigned adder/subtractor, sign-magnitude subtract result.
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   bus.in_valid/A/B/ctrl   operands (ctrl: 0 add, 1 subtract)
//   bus.S       sum or subtraction magnitude (1 cycle latency)
//   bus.Cout    raw ripple carry-out (for subtract: 1 iff A>=B)
//   bus.initialCout  negative flag, set only for subtract with A<B
//   bus.out_valid    high one cycle after in_valid

// One bit of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module four_bit_add_sub (
  input  logic                  clk,
  input  logic                  rst,
  four_bit_add_sub_if.slave     bus
);
  localparam int W      = 4;
  localparam int STAGES = 1;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         neg;
  } res_t;

  logic [W-1:0] a, bx, raw;
  logic [W:0]   c;
  res_t         res_next, res_q;
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;

  assign a    = bus.A;
  // ctrl inverts B and supplies the +1, forming A + ~B + 1 = A - B.
  assign bx   = bus.B ^ {W{bus.ctrl}};
  assign c[0] = bus.ctrl;

  for (genvar i = 0; i < W; i++) begin : g_fa
    fa_cell u_fa (
      .a  (a[i]),
      .b  (bx[i]),
      .ci (c[i]),
      .s  (raw[i]),
      .co (c[i+1])
    );
  end

  always_comb begin
    res_next      = '0;
    res_next.cout = c[W];
    // No carry out of a subtraction means A<B: recomplement to get B-A.
    res_next.neg  = bus.ctrl & ~c[W];
    res_next.s    = res_next.neg ? (~raw + 4'd1) : raw;
  end

  assign vld_pipe = {vld_q, bus.in_valid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (bus.in_valid) res_q <= res_next;
    end
  end

  assign bus.S           = res_q.s;
  assign bus.Cout        = res_q.cout;
  assign bus.initialCout = res_q.neg;
  assign bus.out_valid   = vld_pipe[STAGES];
endmodule

// File: tb/tb_four_bit_add_sub.sv
module tb_four_bit_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  four_bit_add_sub_if bus ();

  four_bit_add_sub dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] s, input logic c,
                         input logic ic, input logic ov);
    chk({tag, ".S"},           bus.S,                   s);
    chk({tag, ".Cout"},        {3'b0, bus.Cout},        {3'b0, c});
    chk({tag, ".initialCout"}, {3'b0, bus.initialCout}, {3'b0, ic});
    chk({tag, ".out_valid"},   {3'b0, bus.out_valid},   {3'b0, ov});
  endtask

  // Drive operands away from the edge; result checked #1 after the next edge.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic c);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.ctrl     = c;
  endtask

  initial begin
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 chk_all("reset_held", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    #1 chk_all("reset_release", 4'h0, 1'b0, 1'b0, 1'b0);

    // 3 + 5 = 8
    @(negedge clk) drive(1'b1, 4'b0011, 4'b0101, 1'b0);
    @(posedge clk) #1 chk_all("add_3_5", 4'b1000, 1'b0, 1'b0, 1'b1);

    // 12 - 3 = 9
    drive(1'b1, 4'b1100, 4'b0011, 1'b1);
    @(posedge clk) #1 chk_all("sub_12_3", 4'b1001, 1'b1, 1'b0, 1'b1);

    // back-to-back: 10+5, then 15-1
    drive(1'b1, 4'b1010, 4'b0101, 1'b0);
    @(posedge clk) #1 chk_all("b2b_add_10_5", 4'b1111, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'b1111, 4'b0001, 1'b1);
    @(posedge clk) #1 chk_all("b2b_sub_15_1", 4'b1110, 1'b1, 1'b0, 1'b1);

    // 15 + 1 wraps with carry
    drive(1'b1, 4'b1111, 4'b0001, 1'b0);
    @(posedge clk) #1 chk_all("add_wrap_15_1", 4'b0000, 1'b1, 1'b0, 1'b1);

    // 6 - 6 = 0, no negative flag
    drive(1'b1, 4'b0110, 4'b0110, 1'b1);
    @(posedge clk) #1 chk_all("sub_equal_6", 4'b0000, 1'b1, 1'b0, 1'b1);

    // 0 - 15 = -15
    drive(1'b1, 4'b0000, 4'b1111, 1'b1);
    @(posedge clk) #1 chk_all("sub_0_15", 4'b1111, 1'b0, 1'b1, 1'b1);

    // 5 - 9 = -4
    drive(1'b1, 4'b0101, 4'b1001, 1'b1);
    @(posedge clk) #1 chk_all("sub_5_9", 4'b0100, 1'b0, 1'b1, 1'b1);

    // in_valid low: operands change, outputs hold
    drive(1'b0, 4'b1001, 4'b0111, 1'b0);
    @(posedge clk) #1 chk_all("hold_1", 4'b0100, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'b0010, 4'b1110, 1'b1);
    @(posedge clk) #1 chk_all("hold_2", 4'b0100, 1'b0, 1'b1, 1'b0);

    // async reset mid-cycle with a pending operation
    drive(1'b1, 4'b0111, 4'b0001, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("async_reset", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk) #1 chk_all("reset_hold_edge", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) begin
      rst = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 1'b0);
    end
    @(posedge clk) #1 chk_all("after_reset_idle", 4'h0, 1'b0, 1'b0, 1'b0);

    // function resumes after reset: 7 + 8 = 15
    drive(1'b1, 4'b0111, 4'b1000, 1'b0);
    @(posedge clk) #1 chk_all("add_7_8", 4'b1111, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    @(posedge clk) #1 chk_all("final_idle", 4'b1111, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
